// File: rtl/sw_seq_mem.sv
// Dual-bank sequence store and launch controller in front of the Smith-Waterman core.
// Host fills the T and Q banks. The block then pulses start and serves the core's read port.
module sw_seq_mem #(
  parameter int unsigned WORD_W = 16,
  parameter int unsigned ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear_i,
  input  logic              ld_valid_i,
  output logic              ld_ready_o,
  input  logic              ld_bank_i,
  input  logic [WORD_W-1:0] ld_data_i,
  input  logic              ld_last_i,
  output logic [ADDR_W:0]   t_len_o,
  output logic [ADDR_W:0]   q_len_o,
  output logic              start_o,
  input  logic              busy_i,
  input  logic              select_T_i,
  input  logic [ADDR_W-1:0] addr_i,
  output logic [WORD_W-1:0] data_o,
  output logic [1:0]        state_o
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam int unsigned PTR_W = ADDR_W + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    WAIT  = 2'd2,
    RUN   = 2'd3
  } state_e;

  state_e                  state_q, state_d;
  logic [1:0][PTR_W-1:0]   ptr_q, ptr_d;
  logic [1:0][PTR_W-1:0]   len_q, len_d;
  logic [1:0]              done_q, done_d;
  logic [1:0]              full_c;
  logic                    start_q, start_d;
  logic [WORD_W-1:0]       data_q;
  logic                    accept_c;
  logic                    wr_en_c;
  logic [ADDR_W-1:0]       wr_addr_c;

  // Index 1 is the T bank, index 0 the Q bank.
  logic [WORD_W-1:0]       bank_q [2][DEPTH];

  assign full_c[0]  = (ptr_q[0] == PTR_W'(DEPTH));
  assign full_c[1]  = (ptr_q[1] == PTR_W'(DEPTH));
  assign ld_ready_o = (state_q == IDLE) & ~done_q[ld_bank_i] & ~full_c[ld_bank_i];
  assign accept_c   = ld_valid_i & ld_ready_o;
  assign wr_en_c    = accept_c & ~clear_i;
  assign wr_addr_c  = ptr_q[ld_bank_i][ADDR_W-1:0];

  // Next-state, load bookkeeping and start pulse.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    len_d   = len_q;
    done_d  = done_q;
    start_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept_c) begin
          ptr_d[ld_bank_i] = ptr_q[ld_bank_i] + PTR_W'(1);
          if (ld_last_i) begin
            len_d[ld_bank_i]  = ptr_q[ld_bank_i] + PTR_W'(1);
            done_d[ld_bank_i] = 1'b1;
          end
        end
        if (done_q[0] & done_q[1] & ~busy_i) state_d = ARMED;
      end
      ARMED: state_d = WAIT;
      WAIT:  if (busy_i) state_d = RUN;
      RUN: begin
        if (!busy_i) begin
          state_d = IDLE;
          ptr_d   = '0;
          len_d   = '0;
          done_d  = '0;
        end
      end
      default: state_d = IDLE;
    endcase

    if (clear_i) begin
      state_d = IDLE;
      ptr_d   = '0;
      len_d   = '0;
      done_d  = '0;
    end

    start_d = (state_d == ARMED);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      len_q   <= '0;
      done_q  <= '0;
      start_q <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      len_q   <= len_d;
      done_q  <= done_d;
      start_q <= start_d;
      data_q  <= bank_q[select_T_i][addr_i];
    end
  end

  // Bank storage is never reset; a same-edge read sees the old word.
  always_ff @(posedge clk) begin
    if (wr_en_c) bank_q[ld_bank_i][wr_addr_c] <= ld_data_i;
  end

  assign t_len_o = len_q[1];
  assign q_len_o = len_q[0];
  assign start_o = start_q;
  assign data_o  = data_q;
  assign state_o = 2'(state_q);

endmodule

// File: tb/tb_sw_seq_mem.sv
// Bench for sw_seq_mem: directed scenarios and random traffic against a behavioural model.
module tb_sw_seq_mem;

  localparam int unsigned WW    = 16;
  localparam int unsigned AW    = 2;
  localparam int          DEPTH = 4;

  logic          clk;
  logic          rst;
  logic          clear_i;
  logic          ld_valid_i;
  logic          ld_ready_o;
  logic          ld_bank_i;
  logic [WW-1:0] ld_data_i;
  logic          ld_last_i;
  logic [AW:0]   t_len_o;
  logic [AW:0]   q_len_o;
  logic          start_o;
  logic          busy_i;
  logic          select_T_i;
  logic [AW-1:0] addr_i;
  logic [WW-1:0] data_o;
  logic [1:0]    state_o;

  sw_seq_mem #(.WORD_W(WW), .ADDR_W(AW)) dut (
    .clk        (clk),
    .rst        (rst),
    .clear_i    (clear_i),
    .ld_valid_i (ld_valid_i),
    .ld_ready_o (ld_ready_o),
    .ld_bank_i  (ld_bank_i),
    .ld_data_i  (ld_data_i),
    .ld_last_i  (ld_last_i),
    .t_len_o    (t_len_o),
    .q_len_o    (q_len_o),
    .start_o    (start_o),
    .busy_i     (busy_i),
    .select_T_i (select_T_i),
    .addr_i     (addr_i),
    .data_o     (data_o),
    .state_o    (state_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Behavioural model: per-bank word lists with write pointer, length and closed flag.
  int            m_st;
  int            m_ptr  [2];
  int            m_len  [2];
  bit            m_done [2];
  logic [WW-1:0] m_mem  [2][DEPTH];
  bit            m_vld  [2][DEPTH];
  logic [WW-1:0] m_data;
  bit            m_dvld;
  bit            m_start;

  task automatic model_clear();
    m_st = 0;
    for (int b = 0; b < 2; b++) begin
      m_ptr[b]  = 0;
      m_len[b]  = 0;
      m_done[b] = 1'b0;
    end
  endtask

  // One clock: check ready before the edge, advance the model, check outputs after.
  task automatic step();
    int            b;
    int            sel;
    int            ad;
    bit            rdy;
    bit            acc;
    bit            both;
    logic [WW-1:0] nd;
    bit            ndv;
    b   = int'(ld_bank_i);
    sel = int'(select_T_i);
    ad  = int'(addr_i);
    rdy = (m_st == 0) && !m_done[b] && (m_ptr[b] < DEPTH);
    #1;
    check("ready", 32'(ld_ready_o), 32'(rdy));
    acc  = ld_valid_i && rdy;
    nd   = m_mem[sel][ad];
    ndv  = m_vld[sel][ad];
    both = m_done[0] && m_done[1];
    @(posedge clk);
    if (clear_i) begin
      model_clear();
    end else begin
      if (acc) begin
        m_mem[b][m_ptr[b]] = ld_data_i;
        m_vld[b][m_ptr[b]] = 1'b1;
        if (ld_last_i) begin
          m_len[b]  = m_ptr[b] + 1;
          m_done[b] = 1'b1;
        end
        m_ptr[b]++;
      end
      case (m_st)
        0: if (both && !busy_i) m_st = 1;
        1: m_st = 2;
        2: if (busy_i) m_st = 3;
        default: if (!busy_i) model_clear();
      endcase
    end
    m_start = (m_st == 1);
    m_data  = nd;
    m_dvld  = ndv;
    #1;
    check("state", 32'(state_o), 32'(m_st));
    check("start", 32'(start_o), 32'(m_start));
    check("t_len", 32'(t_len_o), 32'(m_len[1]));
    check("q_len", 32'(q_len_o), 32'(m_len[0]));
    if (m_dvld) check("data", 32'(data_o), 32'(m_data));
  endtask

  task automatic beat(input bit bank, input logic [WW-1:0] d, input bit last);
    ld_valid_i = 1'b1;
    ld_bank_i  = bank;
    ld_data_i  = d;
    ld_last_i  = last;
    step();
    ld_valid_i = 1'b0;
    ld_last_i  = 1'b0;
  endtask

  initial begin
    rst = 1'b1; clear_i = 1'b0; ld_valid_i = 1'b0; ld_bank_i = 1'b0;
    ld_data_i = '0; ld_last_i = 1'b0; busy_i = 1'b0; select_T_i = 1'b0; addr_i = '0;
    model_clear();
    for (int b = 0; b < 2; b++)
      for (int a = 0; a < DEPTH; a++) begin
        m_mem[b][a] = '0;
        m_vld[b][a] = 1'b0;
      end
    m_data = '0; m_dvld = 1'b1; m_start = 1'b0;

    #2;
    check("rst_state", 32'(state_o), 32'd0);
    check("rst_ready", 32'(ld_ready_o), 32'd1);
    check("rst_start", 32'(start_o), 32'd0);
    check("rst_lens", 32'({t_len_o, q_len_o}), 32'd0);
    check("rst_data", 32'(data_o), 32'd0);
    #10;
    rst = 1'b0;

    // Interleaved load T=3, Q=2, then launch.
    beat(1'b1, 16'h1111, 1'b0);
    beat(1'b0, 16'h4444, 1'b0);
    beat(1'b1, 16'h2222, 1'b0);
    beat(1'b0, 16'h5555, 1'b1);
    beat(1'b1, 16'h3333, 1'b1);
    check("t2_state0", 32'(state_o), 32'd0);
    check("t2_tlen", 32'(t_len_o), 32'd3);
    check("t2_qlen", 32'(q_len_o), 32'd2);
    step();
    check("t2_armed", 32'(state_o), 32'd1);
    check("t2_start_hi", 32'(start_o), 32'd1);
    step();
    check("t2_wait", 32'(state_o), 32'd2);
    check("t2_start_lo", 32'(start_o), 32'd0);

    // Core-side reads while waiting.
    select_T_i = 1'b1; addr_i = 2'd1;
    step();
    check("t3_rd_t1", 32'(data_o), 32'h2222);
    select_T_i = 1'b0; addr_i = 2'd0;
    step();
    check("t3_rd_q0", 32'(data_o), 32'h4444);

    // Core busy for 5 cycles with load attempts, then done.
    busy_i = 1'b1; ld_valid_i = 1'b1; ld_bank_i = 1'b1; ld_data_i = 16'hDEAD;
    for (int i = 0; i < 5; i++) begin
      step();
      check("t5_run", 32'(state_o), 32'd3);
    end
    busy_i = 1'b0; ld_valid_i = 1'b0;
    step();
    check("t5_idle", 32'(state_o), 32'd0);
    check("t5_lens", 32'({t_len_o, q_len_o}), 32'd0);

    // Read-first on a same-edge write to T[0].
    select_T_i = 1'b1; addr_i = 2'd0;
    beat(1'b1, 16'hAAAA, 1'b0);
    check("t6_old", 32'(data_o), 32'h1111);
    step();
    check("t6_new", 32'(data_o), 32'hAAAA);

    // Fill T without last; Q keeps loading; clear recovers.
    beat(1'b1, 16'h0B01, 1'b0);
    beat(1'b1, 16'h0B02, 1'b0);
    beat(1'b1, 16'h0B03, 1'b0);
    ld_valid_i = 1'b1; ld_bank_i = 1'b1;
    #1;
    check("t4_t_full", 32'(ld_ready_o), 32'd0);
    step();
    beat(1'b0, 16'h0C01, 1'b0);
    clear_i = 1'b1; ld_valid_i = 1'b1; ld_bank_i = 1'b0; ld_data_i = 16'hBEEF;
    step();
    clear_i = 1'b0; ld_valid_i = 1'b0; ld_bank_i = 1'b1;
    #1;
    check("t4_t_ready", 32'(ld_ready_o), 32'd1);
    check("t4_tlen", 32'(t_len_o), 32'd0);

    // Reach RUN, then assert reset asynchronously.
    beat(1'b1, 16'h0D01, 1'b1);
    beat(1'b0, 16'h0E01, 1'b1);
    for (int i = 0; i < 6 && state_o != 2'd2; i++) step();
    check("t1_reach_wait", 32'(state_o), 32'd2);
    busy_i = 1'b1;
    step();
    check("t1_run", 32'(state_o), 32'd3);
    rst = 1'b1;
    #1;
    check("t1_state", 32'(state_o), 32'd0);
    check("t1_ready", 32'(ld_ready_o), 32'd1);
    check("t1_start", 32'(start_o), 32'd0);
    check("t1_tlen", 32'(t_len_o), 32'd0);
    check("t1_qlen", 32'(q_len_o), 32'd0);
    model_clear();
    m_data = '0; m_dvld = 1'b1; m_start = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0; busy_i = 1'b0;

    // Randomised traffic.
    for (int i = 0; i < 600; i++) begin
      ld_valid_i = 1'($urandom_range(0, 1));
      ld_bank_i  = 1'($urandom_range(0, 1));
      ld_data_i  = 16'($urandom);
      ld_last_i  = ($urandom_range(0, 4) == 0);
      clear_i    = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 4) == 0) busy_i = ~busy_i;
      select_T_i = 1'($urandom_range(0, 1));
      addr_i     = 2'($urandom_range(0, 3));
      step();
    end
    ld_valid_i = 1'b0; clear_i = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
